// File: rtl/fetch_pair_queue_if.sv
// Fetch-to-decode bundle for the dual-lane instruction queue.
// The master side is fetch plus decode; the slave side is the queue itself.
interface fetch_pair_queue_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
);
  logic                     flush;
  logic                     in_valid1;
  logic                     in_valid2;
  logic [WIDTH-1:0]         PCF1;
  logic [WIDTH-1:0]         PCF2;
  logic [WIDTH-1:0]         InstrF1;
  logic [WIDTH-1:0]         InstrF2;
  logic                     in_ready;
  logic [1:0]               pop_count;
  logic                     out_valid1;
  logic [WIDTH-1:0]         PCD1;
  logic [WIDTH-1:0]         InstrD1;
  logic [WIDTH-1:0]         PCPlus4D1;
  logic                     out_valid2;
  logic [WIDTH-1:0]         PCD2;
  logic [WIDTH-1:0]         InstrD2;
  logic [WIDTH-1:0]         PCPlus4D2;
  logic [$clog2(DEPTH):0]   count;

  modport master (
    output flush, in_valid1, in_valid2, PCF1, PCF2, InstrF1, InstrF2, pop_count,
    input  in_ready, out_valid1, PCD1, InstrD1, PCPlus4D1,
    input  out_valid2, PCD2, InstrD2, PCPlus4D2, count
  );

  modport slave (
    input  flush, in_valid1, in_valid2, PCF1, PCF2, InstrF1, InstrF2, pop_count,
    output in_ready, out_valid1, PCD1, InstrD1, PCPlus4D1,
    output out_valid2, PCD2, InstrD2, PCPlus4D2, count
  );
endinterface

// File: rtl/fetch_pair_queue.sv
// Dual-lane in-order instruction queue between fetch and decode.
// Accepts up to two instructions per cycle; decode retires 0..2 from the head.
module fetch_pair_queue #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  fetch_pair_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [PW-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [CW-1:0]    count_reg, count_next;

  logic [WIDTH-1:0] pc_mem    [DEPTH];
  logic [WIDTH-1:0] instr_mem [DEPTH];
  logic [WIDTH-1:0] pc4_mem   [DEPTH];

  logic             ready;
  logic             push_en;
  logic             push1;
  logic             push2;
  logic [PW-1:0]    slot1;
  logic [PW-1:0]    slot2;
  logic [1:0]       pushed;
  logic [1:0]       pop_clip;
  logic [CW-1:0]    popped;

  // Readiness looks only at the registered occupancy, so a pop never frees room early.
  assign ready   = (count_reg <= CW'(DEPTH - 2));
  assign push_en = ready & (bus.in_valid1 | bus.in_valid2) & ~bus.flush;
  assign push1   = push_en & bus.in_valid1;
  assign push2   = push_en & bus.in_valid2;
  assign slot1   = wr_ptr_reg;
  assign slot2   = wr_ptr_reg + PW'(bus.in_valid1);
  assign pushed  = {1'b0, push1} + {1'b0, push2};

  assign pop_clip = bus.pop_count[1] ? 2'd2 : bus.pop_count;
  assign popped   = (CW'(pop_clip) > count_reg) ? count_reg : CW'(pop_clip);

  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg;
    if (bus.flush) begin
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      count_next  = '0;
    end else begin
      rd_ptr_next = rd_ptr_reg + PW'(popped);
      wr_ptr_next = wr_ptr_reg + PW'(pushed);
      count_next  = count_reg + CW'(pushed) - popped;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Two write ports; slot1 and slot2 never collide when both lanes push.
  always_ff @(posedge clk) begin
    if (push1) begin
      pc_mem[slot1]    <= bus.PCF1;
      instr_mem[slot1] <= bus.InstrF1;
      pc4_mem[slot1]   <= bus.PCF1 + WIDTH'(4);
    end
    if (push2) begin
      pc_mem[slot2]    <= bus.PCF2;
      instr_mem[slot2] <= bus.InstrF2;
      pc4_mem[slot2]   <= bus.PCF2 + WIDTH'(4);
    end
  end

  logic [PW-1:0]    rd_slot  [2];
  logic             rd_valid [2];
  logic [WIDTH-1:0] rd_pc    [2];
  logic [WIDTH-1:0] rd_instr [2];
  logic [WIDTH-1:0] rd_pc4   [2];

  // Slot gi shows the entry gi places behind the head; invalid slots read as zero.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd_slot
      assign rd_slot[gi]  = rd_ptr_reg + PW'(gi);
      assign rd_valid[gi] = (count_reg > CW'(gi));
      assign rd_pc[gi]    = rd_valid[gi] ? pc_mem[rd_slot[gi]]    : '0;
      assign rd_instr[gi] = rd_valid[gi] ? instr_mem[rd_slot[gi]] : '0;
      assign rd_pc4[gi]   = rd_valid[gi] ? pc4_mem[rd_slot[gi]]   : '0;
    end
  endgenerate

  assign bus.in_ready   = ready;
  assign bus.count      = count_reg;
  assign bus.out_valid1 = rd_valid[0];
  assign bus.PCD1       = rd_pc[0];
  assign bus.InstrD1    = rd_instr[0];
  assign bus.PCPlus4D1  = rd_pc4[0];
  assign bus.out_valid2 = rd_valid[1];
  assign bus.PCD2       = rd_pc[1];
  assign bus.InstrD2    = rd_instr[1];
  assign bus.PCPlus4D2  = rd_pc4[1];
endmodule

// File: tb/tb_fetch_pair_queue.sv
// Scoreboarded bench for fetch_pair_queue: stimulus queues the expected post-edge
// snapshot, a monitor on the falling edge pops and compares it.
module tb_fetch_pair_queue;
  localparam int WIDTH = 32;
  localparam int DEPTH = 8;

  logic clk;
  logic rst;

  fetch_pair_queue_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  fetch_pair_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  typedef struct {
    int          id;
    logic        rdy;
    logic        v1;
    logic        v2;
    logic [31:0] cnt;
    logic [31:0] pc1, in1, p41;
    logic [31:0] pc2, in2, p42;
  } exp_t;

  ent_t mq[$];
  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   txn   = 0;

  function automatic logic [31:0] mk_instr(input logic [31:0] pc);
    return pc ^ 32'h1300_0013;
  endfunction

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s txn %0d: got %h expected %h", nm, id, act, req);
    end
  endtask

  // One clock of stimulus; hand_cnt >= 0 supplies a hand-computed occupancy.
  task automatic step(input bit r, input bit f,
                      input bit v1, input logic [31:0] p1, input logic [31:0] i1,
                      input bit v2, input logic [31:0] p2, input logic [31:0] i2,
                      input int pop, input int hand_cnt);
    exp_t e;
    bit   rdy;
    int   n;
    rdy = (mq.size() <= DEPTH - 2);
    if (r || f) begin
      mq.delete();
    end else begin
      n = (pop > 2) ? 2 : pop;
      if (n > mq.size()) n = mq.size();
      repeat (n) void'(mq.pop_front());
      if (rdy) begin
        if (v1) mq.push_back('{pc: p1, ins: i1});
        if (v2) mq.push_back('{pc: p2, ins: i2});
      end
    end
    e.id  = txn++;
    e.rdy = (mq.size() <= DEPTH - 2);
    e.v1  = (mq.size() >= 1);
    e.v2  = (mq.size() >= 2);
    e.cnt = (hand_cnt >= 0) ? hand_cnt : mq.size();
    e.pc1 = e.v1 ? mq[0].pc : 32'h0;
    e.in1 = e.v1 ? mq[0].ins : 32'h0;
    e.p41 = e.v1 ? mq[0].pc + 32'd4 : 32'h0;
    e.pc2 = e.v2 ? mq[1].pc : 32'h0;
    e.in2 = e.v2 ? mq[1].ins : 32'h0;
    e.p42 = e.v2 ? mq[1].pc + 32'd4 : 32'h0;

    rst           = r;
    bus.flush     = f;
    bus.in_valid1 = v1;
    bus.PCF1      = p1;
    bus.InstrF1   = i1;
    bus.in_valid2 = v2;
    bus.PCF2      = p2;
    bus.InstrF2   = i2;
    bus.pop_count = 2'(pop);
    @(posedge clk);
    exp_q.push_back(e);
    #1;
  endtask

  task automatic pair(input logic [31:0] pc, input int pop, input int hand_cnt);
    step(0, 0, 1, pc, mk_instr(pc), 1, pc + 32'd4, mk_instr(pc + 32'd4), pop, hand_cnt);
  endtask

  task automatic idle(input int pop, input int hand_cnt);
    step(0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 32'h0, pop, hand_cnt);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        $display("txn %0d: cnt=%0d rdy=%0d v=%0d%0d PCD1=%h PCD2=%h",
                 e.id, bus.count, bus.in_ready, bus.out_valid1, bus.out_valid2, bus.PCD1, bus.PCD2);
        chk("in_ready",   e.id, 32'(bus.in_ready),   32'(e.rdy));
        chk("out_valid1", e.id, 32'(bus.out_valid1), 32'(e.v1));
        chk("out_valid2", e.id, 32'(bus.out_valid2), 32'(e.v2));
        chk("count",      e.id, 32'(bus.count),      e.cnt);
        chk("PCD1",       e.id, bus.PCD1,            e.pc1);
        chk("InstrD1",    e.id, bus.InstrD1,         e.in1);
        chk("PCPlus4D1",  e.id, bus.PCPlus4D1,       e.p41);
        chk("PCD2",       e.id, bus.PCD2,            e.pc2);
        chk("InstrD2",    e.id, bus.InstrD2,         e.in2);
        chk("PCPlus4D2",  e.id, bus.PCPlus4D2,       e.p42);
      end
    end
  end

  initial begin : stimulus
    rst           = 1'b1;
    bus.flush     = 1'b0;
    bus.in_valid1 = 1'b0;
    bus.in_valid2 = 1'b0;
    bus.PCF1      = '0;
    bus.PCF2      = '0;
    bus.InstrF1   = '0;
    bus.InstrF2   = '0;
    bus.pop_count = '0;

    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(0, 0);

    // First pair, single pop, then clipped pop at count=1.
    step(0, 0, 1, 32'h0, 32'h0050_0093, 1, 32'h4, 32'h00a0_0113, 0, 2);
    idle(1, 1);
    idle(2, 0);

    // Fill to full, offer a pair while full, then drain.
    pair(32'h00, 0, 2);
    pair(32'h08, 0, 4);
    pair(32'h10, 0, 6);
    pair(32'h18, 0, 8);
    pair(32'h20, 0, 8);
    pair(32'h20, 2, 6);
    idle(2, 4);
    idle(2, 2);
    idle(2, 0);

    // Offset by one lane-2-only push so pairs straddle the last entry.
    step(0, 0, 0, 32'h0, 32'h0, 1, 32'h100, mk_instr(32'h100), 0, 1);
    for (int k = 0; k < 10; k++) pair(32'(8 * k), 2, 2);
    idle(2, 0);

    // pop_count of 3 behaves as 2.
    pair(32'h200, 0, 2);
    step(0, 0, 1, 32'h208, mk_instr(32'h208), 0, 32'h0, 32'h0, 0, 3);
    idle(3, 1);
    idle(3, 0);

    // Flush beats a same-cycle push and pop; pointers restart at zero.
    pair(32'h300, 0, 2);
    step(0, 0, 1, 32'h308, mk_instr(32'h308), 0, 32'h0, 32'h0, 0, 3);
    step(0, 1, 1, 32'h400, mk_instr(32'h400), 1, 32'h404, mk_instr(32'h404), 2, 0);
    pair(32'h500, 0, 2);

    // PC+4 wraps modulo 2^32.
    idle(2, 0);
    pair(32'hFFFF_FFF8, 0, 2);

    // Reset overrides push and pop.
    step(1, 0, 1, 32'h600, mk_instr(32'h600), 1, 32'h604, mk_instr(32'h604), 1, 0);
    idle(0, 0);

    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/fetch_pair_queue.md
Name: fetch_pair_queue

Overview:
- Dual-lane instruction buffer that sits directly downstream of the dual PC generator and instruction memory, between the fetch and decode stages.
- Accepts up to two in-order fetched instructions per cycle (lane 1 is older) and presents the two oldest buffered instructions to the two decode lanes.
- Decode consumes 0, 1 or 2 instructions per cycle, so a dependent pair can issue one at a time without stalling fetch immediately.
- A redirect (taken branch or jump resolved in Execute) flushes all buffered instructions.

Parameters:
- WIDTH, 32: PC and instruction width.
- DEPTH, 8: number of single-instruction entries; must be a power of 2 and at least 4.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discard all buffered entries (redirect).
- in_valid1  in  1  lane-1 fetch instruction valid.
- in_valid2  in  1  lane-2 fetch instruction valid.
- PCF1  in  WIDTH  lane-1 PC.
- PCF2  in  WIDTH  lane-2 PC.
- InstrF1  in  WIDTH  lane-1 instruction.
- InstrF2  in  WIDTH  lane-2 instruction.
- in_ready  out  1  queue can accept a full pair this cycle.
- pop_count  in  2  number of instructions decode consumes this cycle (0, 1 or 2; 3 is treated as 2).
- out_valid1  out  1  oldest entry valid.
- PCD1  out  WIDTH  oldest entry PC.
- InstrD1  out  WIDTH  oldest entry instruction.
- PCPlus4D1  out  WIDTH  oldest entry PC+4.
- out_valid2  out  1  second-oldest entry valid.
- PCD2  out  WIDTH  second-oldest entry PC.
- InstrD2  out  WIDTH  second-oldest entry instruction.
- PCPlus4D2  out  WIDTH  second-oldest entry PC+4.
- count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- State
  - Storage array of DEPTH entries, each holding {PC, Instr, PC+4}. PC+4 is computed at write with modulo-2^WIDTH wrap.
  - Head pointer rd_ptr and tail pointer wr_ptr, both $clog2(DEPTH) bits, wrapping modulo DEPTH.
  - Occupancy register count, range 0..DEPTH.
- Reset
  - rd_ptr = 0, wr_ptr = 0, count = 0.
  - Therefore in_ready = 1 and out_valid1 = out_valid2 = 0.
  - All D-side data outputs read 0.
  - Reset overrides flush, push and pop.
- Ready
  - in_ready = (DEPTH - count) >= 2, computed from the registered count only.
  - A same-cycle pop never raises in_ready.
- Push
  - Occurs when in_ready is 1 and at least one in_valid is set.
  - Lanes are written in order: lane 1 at wr_ptr, lane 2 at the next slot.
  - If only in_valid2 is set, lane 2 is written at wr_ptr. No gap entry is ever written.
  - pushed = in_valid1 + in_valid2.
  - When in_ready is 0, inputs are ignored with no state change; fetch must hold its PCs.
- Pop
  - popped = min(pop_count clipped to 2, count).
  - rd_ptr advances by popped. Popping beyond occupancy is silently clipped.
- Count update: count_next = count + pushed - popped, evaluated in the same cycle.
- Latency
  - Fill latency is 1 cycle: an entry pushed in cycle N is visible at the outputs in cycle N+1.
  - There is no input-to-output bypass, even when the queue is empty.
- Outputs (combinational from registered state)
  - out_valid1 = (count >= 1); slot 1 shows the entry at rd_ptr.
  - out_valid2 = (count >= 2); slot 2 shows the entry at rd_ptr+1 (wrapped).
  - Data fields of any invalid slot are forced to 0.
- Flush
  - Synchronous. Next cycle: count = 0, rd_ptr = wr_ptr = 0.
  - Same-cycle push and pop are discarded; flush has priority over both.
- Wrap-around: pointers wrap cleanly, and a pair may straddle entry DEPTH-1 and entry 0 with order preserved.
- Full: count = DEPTH gives in_ready = 0, out_valid1 = out_valid2 = 1.
- Ordering invariant: PCD1 is always the older instruction, and no instruction is duplicated or dropped except by flush or reset.

Test Plan:
- Reset, then an empty cycle: in_ready=1, out_valid1=0, out_valid2=0, count=0, PCD1=0.
- Push PCF1=0x0/0x00500093 and PCF2=0x4/0x00a00113 with pop_count=0. Next cycle: PCD1=0x0, PCPlus4D1=0x4, PCD2=0x4, PCPlus4D2=0x8, count=2.
- From that state, pop_count=1 with no push. Next cycle: PCD1=0x4, out_valid2=0, count=1.
- Push four pairs (PC 0x0..0x1C) with no pops: count=8, in_ready=0. A fifth pair offered is ignored. Then pop 2 per cycle: PCs drain in order 0x0..0x1C, and in_ready rises once count reaches 6.
- Pointer wrap with DEPTH=8: push and pop pairs continuously for 10 cycles (PCs 0x0..0x4C). The outputs track the input sequence with 1-cycle latency and no drops.
- Boundary cases:
  - With count=3, assert flush together with a push and pop_count=2: next cycle count=0, out_valid1=0.
  - With count=1, pop_count=2: next cycle count=0; popping is clipped to 1.
